// File: rtl/buffer_pkg.sv
// Shared defaults and state encodings for the circular buffer and its feeder.
package buffer_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int K_DEF     = 8;
  localparam int J_DEF     = 4;

  typedef enum logic {
    A_FILL = 1'b0,
    A_FULL = 1'b1
  } a_state_e;

  typedef enum logic {
    H_EMPTY = 1'b0,
    H_HOLD  = 1'b1
  } h_state_e;

  function automatic int lane_lo(input int lane, input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/buffer_word_packer_assembler.sv
// Assembly register: collects words into lanes, closes on K words or flush.
module word_assembler
  import buffer_pkg::*;
#(
  parameter int              WIDTH = WIDTH_DEF,
  parameter int              K     = K_DEF,
  parameter logic [WIDTH-1:0] PAD  = '0,
  localparam int             CW    = $clog2(K + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               wr_i,
  input  logic [WIDTH-1:0]   wdata_i,
  input  logic               flush_i,
  input  logic               clr_i,
  output logic [WIDTH*K-1:0] data_o,
  output logic [CW-1:0]      cnt_o,
  output logic               full_o
);

  logic [WIDTH*K-1:0] data_q, data_d, base_data;
  logic [CW-1:0]      cnt_q, cnt_d, base_cnt;
  a_state_e           st_q, st_d, base_st;

  // Lanes start at PAD so a flushed partial group needs no extra fill.
  always_comb begin
    base_data = clr_i ? {K{PAD}} : data_q;
    base_cnt  = clr_i ? '0 : cnt_q;
    base_st   = clr_i ? A_FILL : st_q;
    data_d    = base_data;
    cnt_d     = base_cnt;
    st_d      = base_st;
    if (wr_i) begin
      for (int i = 0; i < K; i++) begin
        if (base_cnt == CW'(i))
          data_d[lane_lo(i, WIDTH) +: WIDTH] = wdata_i;
      end
      cnt_d = base_cnt + CW'(1);
    end
    if (st_d == A_FILL &&
        (cnt_d == CW'(K) || (flush_i && cnt_d != '0)))
      st_d = A_FULL;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= {K{PAD}};
      cnt_q  <= '0;
      st_q   <= A_FILL;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      st_q   <= st_d;
    end
  end

  assign data_o = data_q;
  assign cnt_o  = cnt_q;
  assign full_o = (st_q == A_FULL);

endmodule

// File: rtl/buffer_word_packer.sv
// Word-to-group packer: assembly stage plus holding stage feeding the buffer.
module buffer_word_packer
  import buffer_pkg::*;
#(
  parameter int               WIDTH = WIDTH_DEF,
  parameter int               K     = K_DEF,
  parameter logic [WIDTH-1:0] PAD   = '0,
  localparam int              CW    = $clog2(K + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  input  logic               buf_ready,
  output logic               w_en,
  output logic [WIDTH*K-1:0] par_in,
  output logic [CW-1:0]      grp_len
);

  logic [WIDTH*K-1:0] a_data;
  logic [CW-1:0]      a_cnt;
  logic               a_full;
  logic               consume, xfer, accept;

  h_state_e           h_st_q;
  logic [WIDTH*K-1:0] h_data_q;
  logic [CW-1:0]      h_len_q;

  assign consume  = (h_st_q == H_HOLD) && buf_ready;
  assign xfer     = a_full && (h_st_q == H_EMPTY || consume);
  assign in_ready = rst && (!a_full || xfer);
  assign accept   = in_valid && in_ready;

  word_assembler #(
    .WIDTH (WIDTH),
    .K     (K),
    .PAD   (PAD)
  ) u_asm (
    .clk_i   (clk),
    .rst_ni  (rst),
    .wr_i    (accept),
    .wdata_i (in_data),
    .flush_i (flush),
    .clr_i   (xfer),
    .data_o  (a_data),
    .cnt_o   (a_cnt),
    .full_o  (a_full)
  );

  // Reload wins over consume so back-to-back groups leave no bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_st_q   <= H_EMPTY;
      h_data_q <= '0;
      h_len_q  <= '0;
    end else if (xfer) begin
      h_st_q   <= H_HOLD;
      h_data_q <= a_data;
      h_len_q  <= a_cnt;
    end else if (consume) begin
      h_st_q   <= H_EMPTY;
    end
  end

  assign w_en    = (h_st_q == H_HOLD);
  assign par_in  = h_data_q;
  assign grp_len = h_len_q;

endmodule

// File: tb/tb_buffer_word_packer.sv
// Bench for buffer_word_packer: directed scenarios plus scoreboard soak.
module tb_buffer_word_packer;

  localparam int         W    = 4;
  localparam int         K    = 8;
  localparam int         CW   = $clog2(K + 1);
  localparam logic [W-1:0] PADV = 4'hA;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           flush = 1'b0;
  logic           buf_ready = 1'b0;
  logic           w_en;
  logic [W*K-1:0] par_in;
  logic [CW-1:0]  grp_len;

  int tests = 0;
  int fails = 0;
  int emitted = 0;

  logic [W-1:0]   cur[$];
  logic [W*K-1:0] exp_par[$];
  logic [CW-1:0]  exp_len[$];

  buffer_word_packer #(
    .WIDTH (W),
    .K     (K),
    .PAD   (PADV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .buf_ready (buf_ready),
    .w_en      (w_en),
    .par_in    (par_in),
    .grp_len   (grp_len)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic close_grp();
    logic [W*K-1:0] p;
    p = {K{PADV}};
    foreach (cur[i]) p[i*W +: W] = cur[i];
    exp_par.push_back(p);
    exp_len.push_back(CW'(cur.size()));
    cur.delete();
  endtask

  // One clock: sample before the edge, update model, advance to next negedge.
  task automatic step();
    logic [W*K-1:0] p;
    logic [CW-1:0]  l;
    #2;
    if (w_en && buf_ready) begin
      tests++;
      emitted++;
      if (exp_par.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected par_in=%h grp_len=%0d expected none",
                 par_in, grp_len);
      end else begin
        p = exp_par.pop_front();
        l = exp_len.pop_front();
        if (par_in !== p || grp_len !== l) begin
          fails++;
          $display("FAIL sb_group par_in=%h grp_len=%0d expected %h/%0d",
                   par_in, grp_len, p, l);
        end
      end
    end
    if (in_valid && in_ready) begin
      cur.push_back(in_data);
      if (cur.size() == K) close_grp();
    end
    if (flush && cur.size() > 0) close_grp();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [W-1:0] d, input logic f);
    in_data  = d;
    in_valid = 1'b1;
    flush    = f;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    tests++;
    if ({w_en, par_in, grp_len, in_ready} !== '0) begin
      fails++;
      $display("FAIL reset_outputs w_en=%b par_in=%h grp_len=%0d in_ready=%b expected all 0",
               w_en, par_in, grp_len, in_ready);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release in_ready=%b expected 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_single_group();
    int e0;
    buf_ready = 1'b1;
    e0 = emitted;
    for (int i = 1; i <= 8; i++) send(W'(i), 1'b0);
    repeat (5) step();
    tests++;
    if (emitted - e0 != 1) begin
      fails++;
      $display("FAIL single_pulses got=%0d expected 1", emitted - e0);
    end
  endtask

  task automatic test_backpressure();
    logic first, second;
    buf_ready = 1'b0;
    for (int i = 1; i <= 16; i++) send(W'(i), 1'b0);
    tests++;
    if (in_ready !== 1'b0 || w_en !== 1'b1) begin
      fails++;
      $display("FAIL bp_stall in_ready=%b w_en=%b expected 0/1", in_ready, w_en);
    end
    repeat (3) step();
    tests++;
    if (in_ready !== 1'b0 || par_in !== 32'h87654321) begin
      fails++;
      $display("FAIL bp_hold in_ready=%b par_in=%h expected 0/87654321",
               in_ready, par_in);
    end
    buf_ready = 1'b1;
    first = w_en;
    step();
    second = w_en;
    step();
    tests++;
    if (!(first && second)) begin
      fails++;
      $display("FAIL bp_consecutive w_en=%b%b expected 11", first, second);
    end
    tests++;
    if (in_ready !== 1'b1 || w_en !== 1'b0) begin
      fails++;
      $display("FAIL bp_after in_ready=%b w_en=%b expected 1/0", in_ready, w_en);
    end
  endtask

  task automatic test_flush();
    int e0;
    buf_ready = 1'b1;
    e0 = emitted;
    send(4'h5, 1'b0);
    send(4'h6, 1'b0);
    send(4'h7, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (4) step();
    tests++;
    if (emitted - e0 != 1) begin
      fails++;
      $display("FAIL flush_partial groups=%0d expected 1", emitted - e0);
    end
    e0 = emitted;
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (4) step();
    tests++;
    if (emitted - e0 != 0 || w_en !== 1'b0) begin
      fails++;
      $display("FAIL flush_empty groups=%0d w_en=%b expected 0/0",
               emitted - e0, w_en);
    end
  endtask

  task automatic test_flush_same_cycle();
    int e0;
    buf_ready = 1'b1;
    e0 = emitted;
    send(4'h5, 1'b0);
    send(4'h6, 1'b0);
    send(4'h7, 1'b1);
    for (int i = 1; i <= 9; i++) send(W'(i), 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (5) step();
    tests++;
    if (emitted - e0 != 3) begin
      fails++;
      $display("FAIL flush_same groups=%0d expected 3", emitted - e0);
    end
  endtask

  task automatic test_reset_mid();
    int e0;
    int n;
    buf_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(W'(i), 1'b0);
    n = 0;
    while (!w_en && n < 10) begin
      step();
      n++;
    end
    tests++;
    if (w_en !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_wait w_en=%b expected 1 within 10 cycles", w_en);
    end
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if (w_en !== 1'b0 || par_in !== '0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_async w_en=%b par_in=%h in_ready=%b expected 0/0/0",
               w_en, par_in, in_ready);
    end
    cur.delete();
    exp_par.delete();
    exp_len.delete();
    @(negedge clk);
    rst = 1'b1;
    buf_ready = 1'b1;
    e0 = emitted;
    for (int i = 1; i <= 8; i++) send(W'(i), 1'b0);
    repeat (5) step();
    tests++;
    if (emitted - e0 != 1) begin
      fails++;
      $display("FAIL rstmid_regroup groups=%0d expected 1", emitted - e0);
    end
  endtask

  task automatic test_soak();
    for (int c = 0; c < 3000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = W'($urandom);
      buf_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 7) == 0);
      step();
    end
    in_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    buf_ready = 1'b1;
    repeat (6) step();
    tests++;
    if (exp_par.size() != 0 || cur.size() != 0 || w_en !== 1'b0) begin
      fails++;
      $display("FAIL soak_drain pending=%0d open=%0d w_en=%b expected 0/0/0",
               exp_par.size(), cur.size(), w_en);
    end
  endtask

  initial begin
    test_reset();
    test_single_group();
    test_backpressure();
    test_flush();
    test_flush_same_cycle();
    test_reset_mid();
    test_soak();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
